// File: rtl/riscv_pkg.sv
// Shared LSU types and lane helpers: access size decode, byte-enable and write-lane shifting,
// misalignment rules.
package riscv_pkg;

    typedef enum logic [1:0] {
        LSU_BYTE = 2'b00,
        LSU_HALF = 2'b01,
        LSU_WORD = 2'b10
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BEAT0 = 2'b01,
        ST_BEAT1 = 2'b10,
        ST_RESP  = 2'b11
    } lsu_state_e;

    // Encoding 2'b11 behaves as a word access.
    function automatic lsu_size_e size_decode(input logic [1:0] size);
        return (size == 2'b11) ? LSU_WORD : lsu_size_e'(size);
    endfunction

    // Byte enables across two consecutive words; the upper nibble belongs to the second beat.
    function automatic logic [7:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] base;
        case (size_decode(size))
            LSU_BYTE: base = 8'h01;
            LSU_HALF: base = 8'h03;
            default:  base = 8'h0F;
        endcase
        return base << off;
    endfunction

    function automatic logic [63:0] lane_wdata(input logic [31:0] wdata, input logic [1:0] off);
        return {32'h0, wdata} << {off, 3'b000};
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size_decode(size))
            LSU_BYTE: mis = 1'b0;
            LSU_HALF: mis = (off == 2'd3);
            default:  mis = (off != 2'd0);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables and shifted write data for both beats,
// load extraction from a merged two-word window with sign/zero extension.
module lsu_lane_align
    import riscv_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    input  logic [31:0] rword_lo,
    input  logic [31:0] rword_hi,
    output logic [3:0]  be_lo,
    output logic [3:0]  be_hi,
    output logic [31:0] wdata_lo,
    output logic [31:0] wdata_hi,
    output logic        misaligned,
    output logic [31:0] rdata
);

    logic [7:0]  be_wide;
    logic [63:0] wdata_wide;
    logic [31:0] rshift;

    always_comb begin
        be_wide    = lane_be(size, off);
        wdata_wide = lane_wdata(wdata, off);
        rshift     = 32'({rword_hi, rword_lo} >> {off, 3'b000});
        rdata      = rshift;
        case (size_decode(size))
            LSU_BYTE: rdata = {{24{is_signed & rshift[7]}}, rshift[7:0]};
            LSU_HALF: rdata = {{16{is_signed & rshift[15]}}, rshift[15:0]};
            default:  rdata = rshift;
        endcase
    end

    assign be_lo      = be_wide[3:0];
    assign be_hi      = be_wide[7:4];
    assign wdata_lo   = wdata_wide[31:0];
    assign wdata_hi   = wdata_wide[63:32];
    assign misaligned = is_misaligned(size, off);

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Multi-cycle load/store bus controller with req/ack handshake and per-beat watchdog.
// Optional LSU_MISALIGN_SPLIT_EN: misaligned accesses become two bus beats instead of faulting.
module lsu_bus_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_vld,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    input  logic [1:0]        i_size,
    input  logic              i_signed,
    output logic              o_stall,
    output logic              o_done,
    output logic [31:0]       o_rdata,
    output logic              o_misaligned,
    output logic              o_bus_err,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [3:0]        o_mem_be,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [31:0]       i_mem_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYC - 1);

    lsu_state_e        state, state_d;
    logic              lat_we, lat_we_d, lat_signed, lat_signed_d;
    logic [1:0]        lat_off, lat_off_d, lat_size, lat_size_d;
    logic [31:0]       lat_wdata, lat_wdata_d, rbuf, rbuf_d;
    logic [CNT_W-1:0]  wdog, wdog_d;
    logic              done_d, mis_d, err_d, mem_req_d, mem_we_d;
    logic [31:0]       rdata_d, mem_wdata_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [3:0]        mem_be_d;

    logic              idle, beat1, timeout, split;
    logic [1:0]        la_off, la_size;
    logic              la_signed, la_mis;
    logic [31:0]       la_wdata, la_lo, la_hi, la_wd_lo, la_wd_hi, la_rdata;
    logic [3:0]        la_be_lo, la_be_hi;

    // In IDLE the request is steered straight from the inputs so beat 0 can launch on entry.
    assign idle      = (state == ST_IDLE);
    assign beat1     = (state == ST_BEAT1);
    assign la_off    = idle ? i_addr[1:0] : lat_off;
    assign la_size   = idle ? i_size      : lat_size;
    assign la_signed = idle ? i_signed    : lat_signed;
    assign la_wdata  = idle ? i_wdata     : lat_wdata;
    assign la_lo     = beat1 ? rbuf        : i_mem_rdata;
    assign la_hi     = beat1 ? i_mem_rdata : 32'h0;
    assign split     = la_mis & SPLIT_EN;
    assign timeout   = (TIMEOUT_CYC != 0) && (wdog == WDOG_LAST) && !i_mem_ack;
    assign o_stall   = i_req_vld & ~o_done;

    lsu_lane_align u_align (
        .off        (la_off),
        .size       (la_size),
        .is_signed  (la_signed),
        .wdata      (la_wdata),
        .rword_lo   (la_lo),
        .rword_hi   (la_hi),
        .be_lo      (la_be_lo),
        .be_hi      (la_be_hi),
        .wdata_lo   (la_wd_lo),
        .wdata_hi   (la_wd_hi),
        .misaligned (la_mis),
        .rdata      (la_rdata)
    );

    always_comb begin
        state_d      = state;
        lat_we_d     = lat_we;
        lat_signed_d = lat_signed;
        lat_off_d    = lat_off;
        lat_size_d   = lat_size;
        lat_wdata_d  = lat_wdata;
        rbuf_d       = rbuf;
        wdog_d       = wdog + CNT_W'(1);
        done_d       = 1'b0;
        rdata_d      = 32'h0;
        mis_d        = 1'b0;
        err_d        = 1'b0;
        mem_req_d    = o_mem_req;
        mem_we_d     = o_mem_we;
        mem_addr_d   = o_mem_addr;
        mem_be_d     = o_mem_be;
        mem_wdata_d  = o_mem_wdata;

        case (state)
            ST_IDLE: begin
                if (i_req_vld) begin
                    lat_we_d     = i_we;
                    lat_signed_d = i_signed;
                    lat_off_d    = i_addr[1:0];
                    lat_size_d   = i_size;
                    lat_wdata_d  = i_wdata;
                    if (la_mis && !SPLIT_EN) begin
                        state_d = ST_RESP;
                        done_d  = 1'b1;
                        mis_d   = 1'b1;
                    end else begin
                        state_d     = ST_BEAT0;
                        wdog_d      = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = i_we;
                        mem_addr_d  = {i_addr[ADDR_W-1:2], 2'b00};
                        mem_be_d    = la_be_lo;
                        mem_wdata_d = la_wd_lo;
                    end
                end
            end
            ST_BEAT0, ST_BEAT1: begin
                if (i_mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    mem_be_d  = 4'h0;
                    if (!beat1 && split) begin
                        state_d     = ST_BEAT1;
                        rbuf_d      = i_mem_rdata;
                        wdog_d      = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = lat_we;
                        mem_addr_d  = o_mem_addr + ADDR_W'(4);
                        mem_be_d    = la_be_hi;
                        mem_wdata_d = la_wd_hi;
                    end else begin
                        state_d = ST_RESP;
                        done_d  = 1'b1;
                        rdata_d = lat_we ? 32'h0 : la_rdata;
                    end
                end else if (timeout) begin
                    state_d   = ST_RESP;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    mem_be_d  = 4'h0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state        <= ST_IDLE;
            lat_we       <= 1'b0;
            lat_signed   <= 1'b0;
            lat_off      <= 2'b00;
            lat_size     <= 2'b00;
            lat_wdata    <= 32'h0;
            rbuf         <= 32'h0;
            wdog         <= '0;
            o_done       <= 1'b0;
            o_rdata      <= 32'h0;
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
            o_mem_req    <= 1'b0;
            o_mem_we     <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_be     <= 4'h0;
            o_mem_wdata  <= 32'h0;
        end else begin
            state        <= state_d;
            lat_we       <= lat_we_d;
            lat_signed   <= lat_signed_d;
            lat_off      <= lat_off_d;
            lat_size     <= lat_size_d;
            lat_wdata    <= lat_wdata_d;
            rbuf         <= rbuf_d;
            wdog         <= wdog_d;
            o_done       <= done_d;
            o_rdata      <= rdata_d;
            o_misaligned <= mis_d;
            o_bus_err    <= err_d;
            o_mem_req    <= mem_req_d;
            o_mem_we     <= mem_we_d;
            o_mem_addr   <= mem_addr_d;
            o_mem_be     <= mem_be_d;
            o_mem_wdata  <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed bench for lsu_bus_ctrl: responder with programmable wait states, scoreboard of
// expected completions, bus-side checks per beat. Follows LSU_MISALIGN_SPLIT_EN if defined.
module tb_lsu_bus_ctrl;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_vld = 1'b0, we = 1'b0, sgn = 1'b0, mem_ack = 1'b0;
    logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
    logic [1:0]  size = 2'b00;
    logic        stall, done, misaligned, bus_err, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    lsu_bus_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(4)) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_req_vld    (req_vld),
        .i_we         (we),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .i_size       (size),
        .i_signed     (sgn),
        .o_stall      (stall),
        .o_done       (done),
        .o_rdata      (rdata),
        .o_misaligned (misaligned),
        .o_bus_err    (bus_err),
        .o_mem_req    (mem_req),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_be     (mem_be),
        .o_mem_wdata  (mem_wdata),
        .i_mem_ack    (mem_ack),
        .i_mem_rdata  (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request; the responder acks each beat after a_nwait wait cycles.
    task automatic run_access(
        input string a_tag, input logic a_we, input logic [31:0] a_addr, input logic [31:0] a_wdata,
        input logic [1:0] a_size, input logic a_sgn, input int a_nwait,
        input logic [31:0] a_rd0, input logic [31:0] a_rd1,
        input logic [31:0] e_a0, input logic [3:0] e_b0, input logic [31:0] e_w0,
        input logic [31:0] e_a1, input logic [3:0] e_b1, input logic [31:0] e_w1,
        input int e_beats, input int e_req0, input int e_done,
        input logic [31:0] e_rd, input logic e_mis, input logic e_err);
        int   cyc, beat, waited, req0, nbeats;
        bit   seen;
        exp_t e, got;
        @(negedge clk);
        req_vld = 1'b1; we = a_we; addr = a_addr; wdata = a_wdata; size = a_size; sgn = a_sgn;
        mem_ack = 1'b0;
        e.rdata = e_rd; e.mis = e_mis; e.err = e_err;
        sbq.push_back(e);
        #1 chk({a_tag, "_stall"}, 32'(stall), 32'd1);
        cyc = 0; beat = 0; waited = 0; req0 = 0; nbeats = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            mem_ack = 1'b0;
            if (done) begin
                seen = 1'b1;
                chk({a_tag, "_done_cyc"}, 32'(cyc), 32'(e_done));
                chk({a_tag, "_stall_done"}, 32'(stall), 32'd0);
                chk({a_tag, "_sb_nonempty"}, 32'(sbq.size()), 32'd1);
                if (sbq.size() != 0) begin
                    got = sbq.pop_front();
                    chk({a_tag, "_rdata"}, rdata, got.rdata);
                    chk({a_tag, "_mis"}, 32'(misaligned), 32'(got.mis));
                    chk({a_tag, "_err"}, 32'(bus_err), 32'(got.err));
                end
                req_vld = 1'b0;
            end else if (mem_req) begin
                if (waited == 0) begin
                    nbeats++;
                    chk({a_tag, "_addr"}, mem_addr, (beat == 0) ? e_a0 : e_a1);
                    chk({a_tag, "_be"}, 32'(mem_be), 32'((beat == 0) ? e_b0 : e_b1));
                    chk({a_tag, "_wdata"}, mem_wdata, (beat == 0) ? e_w0 : e_w1);
                    chk({a_tag, "_mem_we"}, 32'(mem_we), 32'(a_we));
                end else if (beat == 0) begin
                    chk({a_tag, "_rdata_quiet"}, rdata, 32'h0);
                end
                if (beat == 0) req0++;
                if (waited == a_nwait) begin
                    mem_ack = 1'b1;
                    mem_rdata = (beat == 0) ? a_rd0 : a_rd1;
                    waited = 0;
                    beat++;
                end else begin
                    waited++;
                end
            end
        end
        chk({a_tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({a_tag, "_beats"}, 32'(nbeats), 32'(e_beats));
        chk({a_tag, "_req0_cycles"}, 32'(req0), 32'(e_req0));
        @(negedge clk);
        chk({a_tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({a_tag, "_req_idle"}, 32'(mem_req), 32'd0);
    endtask

    initial begin
        #12;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_mis", 32'(misaligned), 32'd0);
        chk("rst_err", 32'(bus_err), 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_access("lw_100", 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 0, 32'hDEADBEEF, 32'h0,
                   32'h100, 4'b1111, 32'h0, 32'h0, 4'h0, 32'h0, 1, 1, 2, 32'hDEADBEEF, 1'b0, 1'b0);
        run_access("lb_103", 1'b0, 32'h103, 32'h0, 2'b00, 1'b1, 0, 32'h80AABBCC, 32'h0,
                   32'h100, 4'b1000, 32'h0, 32'h0, 4'h0, 32'h0, 1, 1, 2, 32'hFFFFFF80, 1'b0, 1'b0);
        run_access("lbu_103", 1'b0, 32'h103, 32'h0, 2'b00, 1'b0, 0, 32'h80AABBCC, 32'h0,
                   32'h100, 4'b1000, 32'h0, 32'h0, 4'h0, 32'h0, 1, 1, 2, 32'h00000080, 1'b0, 1'b0);
        run_access("sh_202", 1'b1, 32'h202, 32'h1234ABCD, 2'b01, 1'b0, 2, 32'h0, 32'h0,
                   32'h200, 4'b1100, 32'hABCD0000, 32'h0, 4'h0, 32'h0, 1, 3, 4, 32'h0, 1'b0, 1'b0);
        run_access("lh_102", 1'b0, 32'h102, 32'h0, 2'b01, 1'b1, 0, 32'h80AABBCC, 32'h0,
                   32'h100, 4'b1100, 32'h0, 32'h0, 4'h0, 32'h0, 1, 1, 2, 32'hFFFF80AA, 1'b0, 1'b0);
        run_access("lhu_101", 1'b0, 32'h101, 32'h0, 2'b01, 1'b0, 1, 32'h80AABBCC, 32'h0,
                   32'h100, 4'b0110, 32'h0, 32'h0, 4'h0, 32'h0, 1, 2, 3, 32'h0000AABB, 1'b0, 1'b0);
        run_access("sb_101", 1'b1, 32'h101, 32'h1234565A, 2'b00, 1'b0, 0, 32'h0, 32'h0,
                   32'h100, 4'b0010, 32'h34565A00, 32'h0, 4'h0, 32'h0, 1, 1, 2, 32'h0, 1'b0, 1'b0);
        run_access("lw_top", 1'b0, 32'hFFFFFFFC, 32'h0, 2'b11, 1'b0, 0, 32'h01020304, 32'h0,
                   32'hFFFFFFFC, 4'b1111, 32'h0, 32'h0, 4'h0, 32'h0, 1, 1, 2, 32'h01020304, 1'b0, 1'b0);
`ifdef LSU_MISALIGN_SPLIT_EN
        run_access("lw_0fe", 1'b0, 32'h0FE, 32'h0, 2'b10, 1'b0, 0, 32'h11112222, 32'h33334444,
                   32'h0FC, 4'b1100, 32'h0, 32'h100, 4'b0011, 32'h0, 2, 1, 3, 32'h44441111, 1'b0, 1'b0);
        run_access("lw_wrap", 1'b0, 32'hFFFFFFFE, 32'h0, 2'b10, 1'b0, 0, 32'h11112222, 32'h33334444,
                   32'hFFFFFFFC, 4'b1100, 32'h0, 32'h0, 4'b0011, 32'h0, 2, 1, 3, 32'h44441111, 1'b0, 1'b0);
        run_access("lh_103", 1'b0, 32'h103, 32'h0, 2'b01, 1'b1, 0, 32'h80AABBCC, 32'h11223344,
                   32'h100, 4'b1000, 32'h0, 32'h104, 4'b0001, 32'h0, 2, 1, 3, 32'h00004480, 1'b0, 1'b0);
        run_access("sw_0fe", 1'b1, 32'h0FE, 32'hAABBCCDD, 2'b10, 1'b0, 1, 32'h0, 32'h0,
                   32'h0FC, 4'b1100, 32'hCCDD0000, 32'h100, 4'b0011, 32'h0000AABB, 2, 2, 5, 32'h0, 1'b0, 1'b0);
`else
        run_access("lw_0fe", 1'b0, 32'h0FE, 32'h0, 2'b10, 1'b0, 0, 32'h11112222, 32'h33334444,
                   32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 0, 0, 1, 32'h0, 1'b1, 1'b0);
        run_access("lw_wrap", 1'b0, 32'hFFFFFFFE, 32'h0, 2'b10, 1'b0, 0, 32'h0, 32'h0,
                   32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 0, 0, 1, 32'h0, 1'b1, 1'b0);
        run_access("lh_103", 1'b0, 32'h103, 32'h0, 2'b01, 1'b1, 0, 32'h0, 32'h0,
                   32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 0, 0, 1, 32'h0, 1'b1, 1'b0);
        run_access("sw_0fe", 1'b1, 32'h0FE, 32'hAABBCCDD, 2'b10, 1'b0, 0, 32'h0, 32'h0,
                   32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 0, 0, 1, 32'h0, 1'b1, 1'b0);
`endif
        run_access("sw_tmo", 1'b1, 32'h300, 32'hCAFEF00D, 2'b10, 1'b0, 99, 32'h0, 32'h0,
                   32'h300, 4'b1111, 32'hCAFEF00D, 32'h0, 4'h0, 32'h0, 1, 4, 5, 32'h0, 1'b0, 1'b1);

        // Stray ack while idle must not complete anything.
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        chk("idle_ack_done", 32'(done), 32'd0);
        chk("idle_ack_req", 32'(mem_req), 32'd0);
        mem_ack = 1'b0;

        // Reset while beat 0 waits: request must drop without a clock edge.
        @(negedge clk);
        req_vld = 1'b1; we = 1'b1; addr = 32'h400; wdata = 32'h77; size = 2'b00; sgn = 1'b0;
        @(negedge clk);
        chk("rst_mid_req_up", 32'(mem_req), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_req_drop", 32'(mem_req), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        req_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_access("sb_after_rst", 1'b1, 32'h401, 32'h000000A5, 2'b00, 1'b0, 0, 32'h0, 32'h0,
                   32'h400, 4'b0010, 32'h0000A500, 32'h0, 4'h0, 32'h0, 1, 1, 2, 32'h0, 1'b0, 1'b0);

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
